// File: rtl/ir_shuttle_seq.sv
// ir_shuttle_seq: drives motor enable/direction for a carriage shuttling over N_SENS IR beam sensors,
// with synchronised edge tracking, sensor-order faults, a per-step watchdog and a trip counter.
module ir_shuttle_seq #(
  parameter int N_SENS = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TRIP_W = 4,
  parameter int TO_W = 20,
  parameter int TIMEOUT = 1000000,
  localparam int IDX_W = (N_SENS > 2) ? $clog2(N_SENS) : 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  input  logic              abort,
  input  logic [TRIP_W-1:0] trips_cfg,
  input  logic [N_SENS-1:0] ir,
  output logic              en,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [TRIP_W-1:0] trip_cnt,
  output logic [IDX_W-1:0]  pos
);
  typedef enum logic [2:0] {IDLE, FW_FALL, FW_RISE, BW_FALL, BW_RISE, DONE, FAULT} state_t;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_SENS - 1);
  logic [SYNC_STAGES-1:0][N_SENS-1:0] sync_q;
  logic [N_SENS-1:0] prev_q, lvl, fall, rise, exp_v, opp_v, beyond;
  state_t state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [TRIP_W-1:0] trip_q, trip_d, goal_q, goal_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [1:0] code_q, code_d;
  logic en_q, en_d, dir_q, dir_d, done_q, done_d, fault_q, fault_d;
  logic run, fwd, falling, hit, last, skip, order, tmo;
  assign lvl  = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~lvl;
  assign rise = ~prev_q & lvl;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q  <= '1;
      prev_q  <= '1;
      state_q <= IDLE;
      k_q     <= '0;
      trip_q  <= '0;
      goal_q  <= '0;
      wd_q    <= '0;
      code_q  <= '0;
      en_q    <= 1'b0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ir};
      prev_q  <= lvl;
      state_q <= state_d;
      k_q     <= k_d;
      trip_q  <= trip_d;
      goal_q  <= goal_d;
      wd_q    <= wd_d;
      code_q  <= code_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end
  always_comb begin
    run     = state_q inside {FW_FALL, FW_RISE, BW_FALL, BW_RISE};
    fwd     = state_q == FW_FALL || state_q == FW_RISE;
    falling = state_q == FW_FALL || state_q == BW_FALL;
    exp_v   = falling ? fall : rise;
    opp_v   = falling ? rise : fall;
    for (int i = 0; i < N_SENS; i++) beyond[i] = fwd ? (i > int'(k_q)) : (i < int'(k_q));
    hit     = exp_v[k_q];
    skip    = |(exp_v & beyond);
    order   = |opp_v;
    tmo     = (TIMEOUT != 0) && wd_q == TO_W'(TIMEOUT - 1);
    last    = k_q == (fwd ? K_LAST : '0);
    state_d = state_q;
    k_d     = k_q;
    trip_d  = trip_q;
    goal_d  = goal_q;
    code_d  = code_q;
    wd_d    = run ? wd_q + 1'b1 : '0;
    if (!run) begin
      if (start) begin
        state_d = FW_FALL;
        k_d     = '0;
        trip_d  = '0;
        goal_d  = (trips_cfg == '0) ? TRIP_W'(1) : trips_cfg;
        code_d  = 2'd0;
        wd_d    = '0;
      end
    end else if (abort) begin
      state_d = IDLE;
    end else if (order || skip) begin
      state_d = FAULT;
      code_d  = order ? 2'd2 : 2'd1;
    end else if (tmo) begin
      state_d = FAULT;
      code_d  = 2'd3;
    end else if (hit) begin
      wd_d = '0;
      if (!last) begin
        k_d = fwd ? k_q + 1'b1 : k_q - 1'b1;
      end else begin
        // end of a sweep: the far end starts the backward pass, home ends the trip
        state_d = state_q == FW_FALL ? FW_RISE :
                  state_q == FW_RISE ? BW_FALL :
                  state_q == BW_FALL ? BW_RISE :
                  (TRIP_W'(trip_q + 1'b1) == goal_q) ? DONE : FW_FALL;
        k_d     = (state_q == FW_RISE || state_q == BW_FALL) ? K_LAST : '0;
        trip_d  = state_q == BW_RISE ? trip_q + 1'b1 : trip_q;
      end
    end
  end
  always_comb begin
    en_d    = state_d inside {FW_FALL, FW_RISE, BW_FALL, BW_RISE};
    dir_d   = !(state_d == BW_FALL || state_d == BW_RISE);
    done_d  = state_q == BW_RISE && state_d == DONE;
    fault_d = state_d == FAULT;
  end
  assign en         = en_q;
  assign busy       = en_q;
  assign dir        = dir_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign trip_cnt   = trip_q;
  assign pos        = k_q;
endmodule

// File: doc/ir_shuttle_seq.md
Name: ir_shuttle_seq

Overview:
- Parametrised successor to the fixed 3-sensor IR direction sequencer.
- Drives motor enable/direction for a carriage that shuttles along a track of N_SENS IR beam sensors.
- Each trip is forward over all sensors, then backward to home. A run repeats for a programmed number of trips.
- Adds start/abort control, sensor-order fault detection, a per-step watchdog timeout and a trip counter.
- Contains its own input synchronisers and edge detectors, and sits between the raw IR inputs and the motor driver.

Parameters:
- N_SENS, 3: number of IR sensors, 2..16. ir[0] is the home end; ir[N_SENS-1] is the far end.
- SYNC_STAGES, 2: synchroniser flops per IR input, at least 2.
- TRIP_W, 4: width of trips_cfg and trip_cnt.
- TO_W, 20: width of the watchdog counter.
- TIMEOUT, 1000000: cycles allowed per step. 0 disables the watchdog.

Ports:
- CLK, input, 1: clock.
- RSTn, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a run. Sampled only in IDLE, DONE or FAULT.
- abort, input, 1: stop the run immediately.
- trips_cfg, input, TRIP_W: trips per run, captured at start. 0 is treated as 1.
- ir, input, N_SENS: raw asynchronous sensor levels. 1 = beam clear, 0 = blocked.
- en, output, 1: motor enable.
- dir, output, 1: 1 = forward (away from home), 0 = backward.
- busy, output, 1: a run is in progress.
- done, output, 1: one-cycle pulse when the final trip completes.
- fault, output, 1: sticky fault flag.
- fault_code, output, 2: 0 none, 1 skip, 2 order, 3 timeout.
- trip_cnt, output, TRIP_W: number of trips completed in the current run.
- pos, output, IDX_W: expected sensor index. IDX_W = max(1, clog2(N_SENS)).

Behaviour:
- Reset values: en 0, dir 1, busy 0, done 0, fault 0, fault_code 0, trip_cnt 0, pos 0, state IDLE. All synchroniser and edge flops reset to 1 (beam clear).
- Edge detection: fall[i] = previous synced level 1 and current synced level 0; rise[i] is the inverse. Let E0 be the first CLK edge that samples a new ir level. The FSM acts on that edge at E(SYNC_STAGES).
- States: IDLE, FW_FALL, FW_RISE, BW_FALL, BW_RISE, DONE, FAULT. The index register k drives pos.
- start in IDLE/DONE/FAULT:
  - go to FW_FALL with k=0 and dir=1;
  - clear fault, fault_code and trip_cnt;
  - latch trips_cfg.
- FW_FALL k: on fall[k], increment k. At k=N_SENS-1, go to FW_RISE with k=0.
- FW_RISE k: on rise[k], increment k. At k=N_SENS-1, go to BW_FALL with k=N_SENS-1 and set dir=0 in the same cycle.
- BW_FALL k: on fall[k], decrement k. At k=0, go to BW_RISE with k=N_SENS-1.
- BW_RISE k: on rise[k], decrement k. At k=0 the trip is complete and trip_cnt increments.
  - If the new trip_cnt equals the latched trip count: go to DONE, pulse done for one cycle, set dir=1.
  - Otherwise: go to FW_FALL with k=0 and set dir=1.
- Skip fault (code 1):
  - in forward states, an edge of the expected polarity on a sensor index beyond k;
  - in backward states, the same on an index below k.
- Order fault (code 2): any edge of the opposite polarity while in FW_FALL/FW_RISE/BW_FALL/BW_RISE.
- Edges on sensors behind k of the expected polarity are ignored.
- Watchdog: the counter clears on start and on every k or state advance, and counts while busy. When it reaches TIMEOUT (nonzero), go to FAULT with code 3.
- FAULT: en 0, busy 0, dir 1. fault and fault_code hold until start or reset.
- Same-cycle priority: abort > order/skip fault > timeout > expected edge. An unexpected edge together with the expected edge gives a fault.
- abort while busy: next cycle state IDLE, en 0, dir 1, no done pulse, trip_cnt held. abort outside a run has no effect.
- en = busy = state is one of FW_FALL, FW_RISE, BW_FALL, BW_RISE. en and busy are registered and change in the same cycle as the state.
- start while busy is ignored.
- RSTn asserted mid-run returns every output to its reset value immediately, without waiting for a clock edge.

Test Plan:
- N_SENS=3, trips_cfg=1, start, then the ir sequence for a trip:
  - forward: fall 0,1,2, then rise 0,1,2;
  - backward: fall 2,1,0, then rise 2,1,0.
  - Required: dir goes 1→0 on the rise[2] step, then back to 1 at DONE. done pulses once, trip_cnt=1, en drops the same cycle. Every step is seen SYNC_STAGES cycles after E0.
- trips_cfg=2, two full trip sequences → after trip 1, trip_cnt=1, dir back to 1 and state FW_FALL, with no done pulse. After trip 2, trip_cnt=2 and done pulses once.
- In FW_FALL with k=0, fall on ir[1] → FAULT, fault_code=1, en=0. Then start → fault clears and state is FW_FALL with k=0.
- TIMEOUT=50, start with no ir activity → FAULT with code 3 exactly 50 cycles after start. Repeat with an edge at cycle 40: the timeout fires 50 cycles after that edge instead.
- In BW_RISE, abort together with an unexpected fall[1] → IDLE, fault=0, en=0, dir=1, trip_cnt unchanged.
- RSTn pulsed mid-FW_RISE → all outputs immediately at reset values. A following start runs a clean trip.
